sd_block_receiver: RTL and testbench
====================================

# sd_block_receiver

Receives one SD-card data block from the card's data line(s) and writes it, word by word, into the SDCard module's cache RAM. It is the parametrised successor of the single-line block reader. It adds the following over that reader:
- 1- or 4-lane bus width
- configurable block length and word width
- per-lane CRC16 checking
- end-bit checking
- start-token timeout
- abort

It sits between the SD command/response sequencer, which pulses `enable` after a read command is accepted, and the cache RAM write port.

## Interface
Parameters:
- `LANES`, 1: number of data lines sampled; legal values are 1 and 4.
- `BLOCK_BYTES`, 512: payload bytes per block; must be a power of two, at least 4.
- `WORD_W`, 16: cache word width; must be a multiple of `LANES` and must divide `BLOCK_BYTES*8`.
- `TIMEOUT`, 4095: maximum number of cycles spent waiting for the start token.
- Derived: `ADDR_W = clog2(BLOCK_BYTES*8/WORD_W)` and `DATA_CYC = BLOCK_BYTES*8/LANES`.

Ports:
- `clk400` in 1: SD bus clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `enable` in 1: one-cycle start request. Sampled only in IDLE.
- `abort` in 1: abandons the current block. Returns to IDLE with no `done`.
- `SDin` in `LANES`: card data lines. Lane `LANES-1` is the most significant.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of each block, whether good, bad or timed out.
- `crc_ok` out 1: all lane CRCs matched and all end bits were 1. Valid with `done` and held until the next accepted `enable`.
- `timeout_err` out 1: no start token arrived within `TIMEOUT` cycles. Held like `crc_ok`.
- `casheAddress` out `ADDR_W`: cache word address.
- `casheValue` out `WORD_W`: cache write data.
- `writeCashe` out 1: one-cycle cache write strobe.

## Operation
- State machine:
  - IDLE: if `enable`, go to WAIT_START. Clear the timer, bit counter, CRCs, `crc_ok` and `timeout_err`.
  - WAIT_START: if all `SDin` bits are 0, go to DATA; the start token is not stored. Otherwise, when the timer reaches `TIMEOUT-1`, go to FINISH with `timeout_err` set.
  - DATA: sample `LANES` bits per cycle for `DATA_CYC` cycles, then go to CRC.
  - CRC: sample 16 cycles of per-lane CRC, MSB first, then go to ENDBIT.
  - ENDBIT: sample the end bit on every lane, then go to FINISH.
  - FINISH: assert `done` and go to IDLE.
- Word assembly:
  - A `WORD_W` shift register shifts left by `LANES` each DATA cycle.
  - The new sample fills the low bits; lane `LANES-1` lands at the highest of those positions.
  - The first bit received is the word's MSB.
  - Word k is complete after `(k+1)*WORD_W/LANES` DATA samples.
- CRC:
  - One CRC16-CCITT (x^16+x^12+x^5+1, init 0) per lane.
  - Each lane's CRC is updated only with that lane's DATA bits.
  - In the CRC state, the received bits are compared with the computed remainder, MSB first.
  - Any mismatch, or any end bit of 0, clears `crc_ok`.
- Bad CRC does not suppress cache writes: all `BLOCK_BYTES*8/WORD_W` writes always occur.
- `enable` outside IDLE is ignored. Deasserting `enable` mid-block has no effect.
- `abort`:
  - Takes priority in every state.
  - Next state is IDLE; `done` does not pulse.
  - A `writeCashe` already scheduled for that cycle is suppressed.
  - `crc_ok` and `timeout_err` read 0 afterwards.
- Reset values: state IDLE; `busy`, `done`, `crc_ok`, `timeout_err` and `writeCashe` all 0; `casheAddress` 0; `casheValue` 0.
- Reset asserted mid-block discards the block; no `done` is produced.

## Timing
- `writeCashe` rises the cycle after the last sample of word k. It is high for exactly one cycle, with `casheAddress = k` and `casheValue` = word k, both registered.
- Data and address hold until the next write.
- The last word's write coincides with the first CRC cycle.
- Good block: `done` is high `DATA_CYC + 16 + 1 + 1` cycles after the start-token cycle. This breaks down as:
  - `DATA_CYC` data cycles,
  - 16 CRC cycles,
  - 1 end-bit cycle,
  - 1 cycle in FINISH.
- Timeout: `done` and `timeout_err` are both high `TIMEOUT + 1` cycles after the cycle `enable` was accepted.
- `busy` rises the cycle after `enable` is accepted. It falls on the cycle after `done`.
- The minimum gap from `done` to the next accepted `enable` is 1 cycle.

## Structure
- Package `sd_pkg`:
  - state enum `sd_rx_state_t`,
  - `CRC16_POLY = 16'h1021`,
  - function `crc16_step(crc, bit)`,
  - `START_LEVEL = 0`.
- The package is shared with the future block transmitter.
- Sub-module `sd_crc16_lane`:
  - one serial CRC16 with clear, enable and bit inputs, and a remainder output;
  - instantiated `LANES` times by a generate loop.
- Top level: FSM, timer, bit counter, word shift register and cache write register.

## Test plan
- **Good single-lane block** (LANES=1, 512 bytes): 512 bytes of 0xFF, then CRC 0x7FA1, then end bit 1.
  - Expect 256 writes of 0xFFFF at addresses 0..255.
  - Expect `done` 4114 cycles after the start token, with `crc_ok`=1.
- **Corrupt CRC**: same block with CRC bit 0 flipped.
  - All 256 writes still occur; `done` pulses with `crc_ok`=0.
- **Timeout** (TIMEOUT=100): hold `SDin` high after `enable`.
  - `done` and `timeout_err`=1 after 101 cycles, with no writes.
- **Four-lane ordering** (LANES=4, 8 bytes, WORD_W=16): nibbles 1,2,3,4,5,6,7,8,… with per-lane CRCs.
  - Expect `casheValue` 0x1234 at address 0 and 0x5678 at address 1, `crc_ok`=1.
- **Abort**: assert `abort` in DATA after word 10's write.
  - Return to IDLE next cycle; no further writes; no `done`; new `enable` accepted.
- **Reset mid-CRC**: assert `reset` during the CRC phase.
  - All outputs read 0 immediately; state is IDLE; a following good block succeeds.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD data-path definitions: receiver states, CRC16-CCITT constants and step function.
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_ENDBIT     = 3'd4,
        ST_FINISH     = 3'd5
    } sd_rx_state_t;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic        START_LEVEL = 1'b0;

    // One serial step of x^16+x^12+x^5+1, MSB-first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic in_bit);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ in_bit) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_block_receiver_crc.sv
// Serial CRC16-CCITT accumulator for one SD data lane.
module sd_crc16_lane
    import sd_pkg::*;
(
    input  logic        clk400,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_crc <= 16'h0000;
        end else if (i_clr) begin
            r_crc <= 16'h0000;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sd_block_receiver.sv
// Receives one SD data block on 1 or 4 lanes, writes it word by word into the cache RAM
// and reports per-lane CRC / end-bit status or a start-token timeout.
module sd_block_receiver
    import sd_pkg::*;
#(
    parameter  int unsigned LANES       = 1,
    parameter  int unsigned BLOCK_BYTES = 512,
    parameter  int unsigned WORD_W      = 16,
    parameter  int unsigned TIMEOUT     = 4095,
    localparam int unsigned ADDR_W      = $clog2(BLOCK_BYTES * 8 / WORD_W)
) (
    input  logic              clk400,
    input  logic              reset,
    input  logic              enable,
    input  logic              abort,
    input  logic [LANES-1:0]  SDin,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] casheAddress,
    output logic [WORD_W-1:0] casheValue,
    output logic              writeCashe
);

    localparam int unsigned DATA_CYC = BLOCK_BYTES * 8 / LANES;
    localparam int unsigned WORD_CYC = WORD_W / LANES;
    localparam int unsigned WCYC_LG  = $clog2(WORD_CYC);
    // Counter also sequences the 16 CRC cycles, so it is never narrower than 4 bits.
    localparam int unsigned CNT_W    = ($clog2(DATA_CYC) > 4) ? $clog2(DATA_CYC) : 4;
    localparam int unsigned TMR_W    = $clog2(TIMEOUT + 1);

    sd_rx_state_t      r_state;
    sd_rx_state_t      w_next_state;
    logic [TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_next;
    logic [15:0]       w_crc [LANES];
    logic              w_crc_clr;
    logic              w_crc_en;
    logic              w_crc_miss;
    logic              w_start;
    logic              w_tmo;
    logic              w_data_last;
    logic              w_crc_last;
    logic              w_word_last;
    logic              r_good;

    logic              r_busy;
    logic              r_done;
    logic              r_crc_ok;
    logic              r_tmo_err;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_value;
    logic              r_we;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sd_crc16_lane u_crc (
            .clk400 (clk400),
            .reset  (reset),
            .i_clr  (w_crc_clr),
            .i_en   (w_crc_en),
            .i_bit  (SDin[g]),
            .o_crc  (w_crc[g])
        );
    end

    // Newest sample enters at the low end; truncation drops the oldest bits.
    assign w_shift_next = WORD_W'({r_shift, SDin});

    // Next-state and per-cycle control decode.
    always_comb begin
        w_next_state = r_state;
        w_crc_clr    = 1'b0;
        w_crc_en     = 1'b0;
        w_crc_miss   = 1'b0;
        w_start      = (SDin == {LANES{START_LEVEL}});
        w_tmo        = (r_timer == TMR_W'(TIMEOUT - 1));
        w_data_last  = (r_bitcnt == CNT_W'(DATA_CYC - 1));
        w_crc_last   = (r_bitcnt[3:0] == 4'hF);
        w_word_last  = ((r_bitcnt & CNT_W'(WORD_CYC - 1)) == CNT_W'(WORD_CYC - 1));
        for (int l = 0; l < LANES; l++) begin
            w_crc_miss = w_crc_miss | (SDin[l] != w_crc[l][~r_bitcnt[3:0]]);
        end

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_WAIT_START;
                    w_crc_clr    = 1'b1;
                end
            end
            ST_WAIT_START: begin
                if (w_start) begin
                    w_next_state = ST_DATA;
                end else if (w_tmo) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_DATA: begin
                w_crc_en = 1'b1;
                if (w_data_last) begin
                    w_next_state = ST_CRC;
                end
            end
            ST_CRC: begin
                if (w_crc_last) begin
                    w_next_state = ST_ENDBIT;
                end
            end
            ST_ENDBIT: w_next_state = ST_FINISH;
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase

        if (abort) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: timer, bit counter, word assembly, cache write and status flags.
    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_timer   <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_good    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_crc_ok  <= 1'b0;
            r_tmo_err <= 1'b0;
            r_addr    <= '0;
            r_value   <= '0;
            r_we      <= 1'b0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE);
            r_done <= (w_next_state == ST_FINISH);
            r_we   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_timer   <= '0;
                        r_bitcnt  <= '0;
                        r_good    <= 1'b1;
                        r_crc_ok  <= 1'b0;
                        r_tmo_err <= 1'b0;
                    end
                end
                ST_WAIT_START: begin
                    r_timer <= r_timer + TMR_W'(1);
                    if (!w_start && w_tmo) begin
                        r_tmo_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    r_shift  <= w_shift_next;
                    r_bitcnt <= w_data_last ? '0 : r_bitcnt + CNT_W'(1);
                    if (w_word_last) begin
                        r_we    <= 1'b1;
                        r_value <= w_shift_next;
                        r_addr  <= ADDR_W'(r_bitcnt >> WCYC_LG);
                    end
                end
                ST_CRC: begin
                    r_bitcnt <= r_bitcnt + CNT_W'(1);
                    if (w_crc_miss) begin
                        r_good <= 1'b0;
                    end
                end
                ST_ENDBIT: begin
                    r_crc_ok <= r_good & (&SDin);
                end
                default: ;
            endcase

            if (abort) begin
                r_we      <= 1'b0;
                r_crc_ok  <= 1'b0;
                r_tmo_err <= 1'b0;
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign crc_ok       = r_crc_ok;
    assign timeout_err  = r_tmo_err;
    assign casheAddress = r_addr;
    assign casheValue   = r_value;
    assign writeCashe   = r_we;

endmodule

// File: tb/tb_sd_block_receiver.sv
// Randomized self-checking bench: a 1-lane 512-byte receiver and a 4-lane 8-byte receiver
// checked against a byte-level reference model of the SD block format.
module tb_sd_block_receiver;

    localparam int unsigned TO      = 100;
    localparam int          BYTES_A = 512;
    localparam int          BYTES_B = 8;

    logic        clk400 = 1'b0;
    logic        rst;
    logic        en_a, ab_a, sd_a;
    logic        en_b, ab_b;
    logic [3:0]  sd_b;
    logic [1:0]  busy_v, done_v, ok_v, to_v, we_v;
    logic [7:0]  addr_a;
    logic [1:0]  addr_b;
    logic [15:0] val_v [2];

    typedef struct {
        int addr;
        int val;
        int cyc;
    } wr_t;

    wr_t          wq[$];
    byte unsigned payload [512];
    int           cyc = 0;
    int           n_total = 0;
    int           n_bad = 0;
    int           done_cnt [2] = '{0, 0};
    int           done_cyc [2] = '{0, 0};
    logic         done_ok [2] = '{1'b0, 1'b0};
    logic         done_to [2] = '{1'b0, 1'b0};
    logic         busy_after [2] = '{1'b1, 1'b1};
    logic         post_done [2] = '{1'b0, 1'b0};

    sd_block_receiver #(.LANES(1), .BLOCK_BYTES(BYTES_A), .WORD_W(16), .TIMEOUT(TO)) u_dut_a (
        .clk400(clk400), .reset(rst), .enable(en_a), .abort(ab_a), .SDin(sd_a),
        .busy(busy_v[0]), .done(done_v[0]), .crc_ok(ok_v[0]), .timeout_err(to_v[0]),
        .casheAddress(addr_a), .casheValue(val_v[0]), .writeCashe(we_v[0])
    );

    sd_block_receiver #(.LANES(4), .BLOCK_BYTES(BYTES_B), .WORD_W(16), .TIMEOUT(TO)) u_dut_b (
        .clk400(clk400), .reset(rst), .enable(en_b), .abort(ab_b), .SDin(sd_b),
        .busy(busy_v[1]), .done(done_v[1]), .crc_ok(ok_v[1]), .timeout_err(to_v[1]),
        .casheAddress(addr_b), .casheValue(val_v[1]), .writeCashe(we_v[1])
    );

    always #5 clk400 = ~clk400;

    always @(posedge clk400) cyc <= cyc + 1;

    // Record cache writes and done pulses as observed mid-cycle.
    always @(negedge clk400) begin
        for (int i = 0; i < 2; i++) begin
            if (post_done[i]) busy_after[i] = busy_v[i];
            post_done[i] = done_v[i];
            if (done_v[i]) begin
                done_cnt[i] = done_cnt[i] + 1;
                done_cyc[i] = cyc;
                done_ok[i]  = ok_v[i];
                done_to[i]  = to_v[i];
            end
            if (we_v[i]) begin
                wr_t w;
                w.addr = (i == 0) ? int'(addr_a) : int'(addr_b);
                w.val  = int'(val_v[i]);
                w.cyc  = cyc;
                wq.push_back(w);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int inst, input logic en, input logic ab, input logic [3:0] sd);
        if (inst == 0) begin
            en_a = en; ab_a = ab; sd_a = sd[0];
        end else begin
            en_b = en; ab_b = ab; sd_b = sd;
        end
    endtask

    task automatic chk_zero(input int inst);
        chk("zero_busy", 32'(busy_v[inst]), 0);
        chk("zero_done", 32'(done_v[inst]), 0);
        chk("zero_crc_ok", 32'(ok_v[inst]), 0);
        chk("zero_tmo", 32'(to_v[inst]), 0);
        chk("zero_we", 32'(we_v[inst]), 0);
        chk("zero_addr", (inst == 0) ? 32'(addr_a) : 32'(addr_b), 0);
        chk("zero_val", 32'(val_v[inst]), 0);
    endtask

    // Bit idx of the block as one MSB-first serial stream.
    function automatic logic sbit(input int idx);
        byte unsigned b;
        b = payload[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    // Lane l carries stream bit c*L + (L-1-l) in cycle c (highest lane gets the earliest bit).
    function automatic logic [15:0] ref_crc(input int lanes, input int lane, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ sbit(i * lanes + lanes - 1 - lane);
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic run_block(input int inst, input int flip_lane, input int flip_bit,
                             input logic [3:0] end_mask, input int abort_c, input int reset_j,
                             input bit en_noise);
        int          lanes, nb, dcyc, wc, t_tok, d0, gap, exp_wr;
        logic [15:0] crc [4];
        logic [3:0]  v, lmask;
        logic        exp_ok, en;
        bit          stop;
        lanes  = (inst == 0) ? 1 : 4;
        nb     = (inst == 0) ? BYTES_A : BYTES_B;
        lmask  = (inst == 0) ? 4'h1 : 4'hF;
        dcyc   = nb * 8 / lanes;
        wc     = 16 / lanes;
        exp_wr = nb / 2;
        stop   = 1'b0;
        for (int l = 0; l < 4; l++) crc[l] = (l < lanes) ? ref_crc(lanes, l, dcyc) : 16'h0000;
        exp_ok = (flip_lane < 0) && ((end_mask & lmask) == 4'h0);
        wq.delete();
        d0 = done_cnt[inst];
        busy_after[inst] = 1'b1;

        @(negedge clk400) set_in(inst, 1'b1, 1'b0, 4'hF);
        @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'hF);
        chk("busy_rise", 32'(busy_v[inst]), 1);
        gap = int'($urandom_range(0, 4));
        repeat (gap) @(negedge clk400);
        @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'h0);
        t_tok = cyc;

        for (int c = 0; c < dcyc && !stop; c++) begin
            for (int l = 0; l < 4; l++) v[l] = (l < lanes) ? sbit(c * lanes + lanes - 1 - l) : 1'b1;
            en = en_noise && ($urandom_range(0, 3) == 0);
            @(negedge clk400) set_in(inst, en, (c == abort_c), v);
            if (c == abort_c) begin
                stop   = 1'b1;
                exp_wr = c / wc;
                @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'hF);
                chk("abort_busy", 32'(busy_v[inst]), 0);
                chk("abort_we", 32'(we_v[inst]), 0);
                chk("abort_crc_ok", 32'(ok_v[inst]), 0);
                chk("abort_tmo", 32'(to_v[inst]), 0);
                repeat (40) @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
                set_in(inst, 1'b0, 1'b0, 4'hF);
            end
        end

        for (int j = 0; j < 16 && !stop; j++) begin
            for (int l = 0; l < 4; l++) begin
                v[l] = (l < lanes) ? crc[l][15 - j] : 1'b1;
                if (l == flip_lane && j == 15 - flip_bit) v[l] = ~v[l];
            end
            @(negedge clk400) set_in(inst, 1'b0, 1'b0, v);
            if (j == reset_j) begin
                stop = 1'b1;
                rst  = 1'b1;
                #1;
                chk_zero(inst);
                @(negedge clk400) rst = 1'b0;
                set_in(inst, 1'b0, 1'b0, 4'hF);
            end
        end

        if (!stop) begin
            @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'hF ^ end_mask);
            @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'hF);
            for (int i = 0; i < 10 && done_cnt[inst] == d0; i++) @(negedge clk400);
            chk("done_count", 32'(done_cnt[inst] - d0), 1);
            chk("done_latency", 32'(done_cyc[inst] - t_tok), 32'(dcyc + 18));
            chk("crc_ok", 32'(done_ok[inst]), 32'(exp_ok));
            chk("tmo_clear", 32'(done_to[inst]), 0);
            repeat (2) @(negedge clk400);
            chk("busy_fall", 32'(busy_after[inst]), 0);
            chk("crc_ok_hold", 32'(ok_v[inst]), 32'(exp_ok));
        end else begin
            repeat (3) @(negedge clk400);
            chk("no_done", 32'(done_cnt[inst] - d0), 0);
            chk("idle_after_stop", 32'(busy_v[inst]), 0);
        end

        chk("wr_count", 32'(wq.size()), 32'(exp_wr));
        for (int k = 0; k < wq.size() && k < exp_wr; k++) begin
            chk("wr_addr", 32'(wq[k].addr), 32'(k));
            chk("wr_val", 32'(wq[k].val), {16'h0, payload[2 * k], payload[2 * k + 1]});
            chk("wr_time", 32'(wq[k].cyc - t_tok), 32'((k + 1) * wc + 1));
        end
    endtask

    task automatic run_timeout(input int inst);
        int t_en, d0;
        wq.delete();
        d0 = done_cnt[inst];
        busy_after[inst] = 1'b1;
        @(negedge clk400) set_in(inst, 1'b1, 1'b0, 4'hF);
        t_en = cyc;
        @(negedge clk400) set_in(inst, 1'b0, 1'b0, 4'hF);
        for (int i = 0; i < int'(TO) + 20 && done_cnt[inst] == d0; i++) @(negedge clk400);
        chk("tmo_done_count", 32'(done_cnt[inst] - d0), 1);
        chk("tmo_latency", 32'(done_cyc[inst] - t_en), 32'(TO + 1));
        chk("tmo_flag", 32'(done_to[inst]), 1);
        chk("tmo_crc_ok", 32'(done_ok[inst]), 0);
        repeat (2) @(negedge clk400);
        chk("tmo_busy_fall", 32'(busy_after[inst]), 0);
        chk("tmo_hold", 32'(to_v[inst]), 1);
        chk("tmo_no_writes", 32'(wq.size()), 0);
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 512; i++) payload[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fl, fb, r;
        logic [3:0] em;
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 4'hF);
        set_in(1, 1'b0, 1'b0, 4'hF);
        repeat (3) @(negedge clk400);
        chk_zero(0);
        chk_zero(1);
        @(negedge clk400) rst = 1'b0;
        @(negedge clk400);
        chk_zero(0);

        for (int i = 0; i < 512; i++) payload[i] = 8'hFF;
        run_block(0, -1, 0, 4'h0, -1, -1, 1'b0);
        run_block(0, 0, 0, 4'h0, -1, -1, 1'b0);
        rand_payload();
        run_block(0, -1, 0, 4'h0, -1, -1, 1'b1);
        run_timeout(0);
        rand_payload();
        run_block(0, -1, 0, 4'h0, 176, -1, 1'b0);
        rand_payload();
        run_block(0, -1, 0, 4'h0, -1, -1, 1'b0);

        payload[0] = 8'h12; payload[1] = 8'h34; payload[2] = 8'h56; payload[3] = 8'h78;
        payload[4] = 8'h9A; payload[5] = 8'hBC; payload[6] = 8'hDE; payload[7] = 8'hF0;
        run_block(1, -1, 0, 4'h0, -1, -1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            rand_payload();
            r  = int'($urandom_range(0, 3));
            fl = -1;
            fb = 0;
            em = 4'h0;
            if (r == 0) begin
                fl = int'($urandom_range(0, 3));
                fb = int'($urandom_range(0, 15));
            end else if (r == 1) begin
                em = 4'(1 << $urandom_range(0, 3));
            end
            run_block(1, fl, fb, em, -1, -1, 1'b1);
        end

        run_timeout(1);
        rand_payload();
        run_block(1, -1, 0, 4'h0, -1, 5, 1'b0);
        rand_payload();
        run_block(1, -1, 0, 4'h0, -1, -1, 1'b0);
        rand_payload();
        run_block(1, -1, 0, 4'h0, 7, -1, 1'b0);
        rand_payload();
        run_block(1, -1, 0, 4'h0, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
